xocc_cmd_queue: RTL and testbench

- Parametrised command queue between the coprocessor command port and xocc_decoder. It replaces the fixed 16x96 vendor FIFO.
- Accepts commands one word at a time and assembles CMD_WORD_NUM words into one command.
- Buffers FIFO_DEPTH commands and presents them first-word-fall-through with a valid/ready pop.
- Adds programmable almost-full, occupancy count, flush and framing-error detection.

---
 rtl/xocc_cmd_queue.sv | 149 ++++++++++++++
 tb/tb_xocc_cmd_queue.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xocc_cmd_queue.sv
// rtl/xocc_cmd_queue.sv - parametrised command queue with word assembly, FWFT pop, occupancy flags and framing checks
//
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   in_word/in_sop    : incoming command word and first-word marker
//   in_valid/in_ready : word handshake; in_ready = !full && !flush
//   out_cmd           : head command, word 0 at LSBs (valid while out_valid)
//   out_valid/out_ready : head pop handshake
//   flush             : drop all queued commands and any partial command
//   count/empty/full/almost_full : registered occupancy status
//   err_frame/err_clr : sticky framing error and its clear
module xocc_cmd_queue #(
  parameter int CMD_WORD_WIDTH = 32,
  parameter int CMD_WORD_NUM   = 3,
  parameter int FIFO_DEPTH     = 16,
  parameter int AF_THRESH      = 14,
  parameter int CNT_WIDTH      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [CMD_WORD_WIDTH-1:0]              in_word,
  input  logic                                   in_sop,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  output logic [CMD_WORD_NUM*CMD_WORD_WIDTH-1:0] out_cmd,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  input  logic                                   flush,
  output logic [CNT_WIDTH-1:0]                   count,
  output logic                                   empty,
  output logic                                   full,
  output logic                                   almost_full,
  output logic                                   err_frame,
  input  logic                                   err_clr
);

  localparam int CMD_WIDTH = CMD_WORD_NUM * CMD_WORD_WIDTH;
  localparam int PTR_W     = $clog2(FIFO_DEPTH);
  localparam int WIDX_W    = (CMD_WORD_NUM > 1) ? $clog2(CMD_WORD_NUM) : 1;
  localparam logic [WIDX_W-1:0]    WIDX_LAST = WIDX_W'(CMD_WORD_NUM - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_FULL  = CNT_WIDTH'(FIFO_DEPTH);
  localparam logic [CNT_WIDTH-1:0] CNT_AF    = CNT_WIDTH'(AF_THRESH);

  logic [CMD_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [CMD_WIDTH-1:0] asm_q;
  logic [CMD_WIDTH-1:0] asm_next;
  logic [WIDX_W-1:0]    widx;
  logic [WIDX_W-1:0]    slot;
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [CNT_WIDTH-1:0] cnt_next;
  logic accept, restart, drop, store, push, pop;

  assign in_ready = !full && !flush;
  assign accept   = in_valid && in_ready;

  generate
    if (CMD_WORD_NUM > 1) begin : g_frame
      // sop in mid-command restarts assembly; a non-sop word with nothing
      // in progress has no command to belong to and is discarded.
      assign restart = in_sop && (widx != '0);
      assign drop    = !in_sop && (widx == '0);
    end else begin : g_noframe
      assign restart = 1'b0;
      assign drop    = 1'b0;
    end
  endgenerate

  assign store = accept && !drop;
  assign slot  = restart ? '0 : widx;
  assign push  = store && (slot == WIDX_LAST);
  assign pop   = out_valid && out_ready && !flush;

  // The completed command includes the word arriving this cycle, so the
  // FIFO write takes the merged value rather than the assembly register.
  always_comb begin
    asm_next = asm_q;
    asm_next[int'(slot)*CMD_WORD_WIDTH +: CMD_WORD_WIDTH] = in_word;
  end

  always_comb begin
    cnt_next = count;
    case ({push, pop})
      2'b10:   cnt_next = count + CNT_WIDTH'(1);
      2'b01:   cnt_next = count - CNT_WIDTH'(1);
      default: cnt_next = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      widx        <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      empty       <= 1'b1;
      full        <= 1'b0;
      almost_full <= 1'b0;
      out_valid   <= 1'b0;
      err_frame   <= 1'b0;
    end else begin
      // A new framing error wins over a clear in the same cycle.
      if (accept && (drop || restart)) begin
        err_frame <= 1'b1;
      end else if (err_clr) begin
        err_frame <= 1'b0;
      end

      if (flush) begin
        widx        <= '0;
        wr_ptr      <= '0;
        rd_ptr      <= '0;
        count       <= '0;
        empty       <= 1'b1;
        full        <= 1'b0;
        almost_full <= 1'b0;
        out_valid   <= 1'b0;
      end else begin
        if (store) begin
          widx <= push ? '0 : slot + WIDX_W'(1);
        end
        if (push) begin
          wr_ptr <= wr_ptr + PTR_W'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PTR_W'(1);
        end
        count       <= cnt_next;
        empty       <= (cnt_next == '0);
        full        <= (cnt_next == CNT_FULL);
        almost_full <= (cnt_next >= CNT_AF);
        out_valid   <= (cnt_next != '0);
      end
    end
  end

  // Data storage carries no reset; out_cmd is only meaningful with out_valid.
  always_ff @(posedge clk) begin
    if (store) begin
      asm_q <= asm_next;
    end
    if (push) begin
      mem[wr_ptr] <= asm_next;
    end
  end

  assign out_cmd = mem[rd_ptr];

endmodule

// File: tb/tb_xocc_cmd_queue.sv
// tb/tb_xocc_cmd_queue.sv - self-checking scoreboard bench for xocc_cmd_queue
module tb_xocc_cmd_queue;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // default instance: 3 words x 32, depth 16, AF 14
  logic        rst, in_sop, in_valid, in_ready, out_valid, out_ready, flush;
  logic        empty, full, almost_full, err_frame, err_clr;
  logic [31:0] in_word;
  logic [95:0] out_cmd;
  logic [4:0]  count;

  // single-word instance: depth 4, AF 3
  logic        p_rst, p_in_sop, p_in_valid, p_in_ready, p_out_valid, p_out_ready, p_flush;
  logic        p_empty, p_full, p_almost_full, p_err_frame, p_err_clr;
  logic [31:0] p_in_word, p_out_cmd;
  logic [2:0]  p_count;

  int checks = 0;
  int errors = 0;
  int peak   = 0;
  logic [95:0] sb[$];
  logic [31:0] sb1[$];

  xocc_cmd_queue u0 (
    .clk(clk), .rst(rst), .in_word(in_word), .in_sop(in_sop), .in_valid(in_valid),
    .in_ready(in_ready), .out_cmd(out_cmd), .out_valid(out_valid), .out_ready(out_ready),
    .flush(flush), .count(count), .empty(empty), .full(full), .almost_full(almost_full),
    .err_frame(err_frame), .err_clr(err_clr)
  );

  xocc_cmd_queue #(.CMD_WORD_WIDTH(32), .CMD_WORD_NUM(1), .FIFO_DEPTH(4), .AF_THRESH(3)) u1 (
    .clk(clk), .rst(p_rst), .in_word(p_in_word), .in_sop(p_in_sop), .in_valid(p_in_valid),
    .in_ready(p_in_ready), .out_cmd(p_out_cmd), .out_valid(p_out_valid), .out_ready(p_out_ready),
    .flush(p_flush), .count(p_count), .empty(p_empty), .full(p_full), .almost_full(p_almost_full),
    .err_frame(p_err_frame), .err_clr(p_err_clr)
  );

  // pop monitors: every handshake on the output side is checked against the scoreboard
  always @(negedge clk) begin
    if (!rst && !flush && out_valid && out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL u0_unexpected_pop got=%h required=no_pop", out_cmd);
      end else begin
        logic [95:0] exp_cmd;
        exp_cmd = sb.pop_front();
        if (out_cmd !== exp_cmd) begin
          errors++;
          $display("FAIL u0_pop_data got=%h required=%h", out_cmd, exp_cmd);
        end
      end
    end
    if (!p_rst && !p_flush && p_out_valid && p_out_ready) begin
      checks++;
      if (sb1.size() == 0) begin
        errors++;
        $display("FAIL u1_unexpected_pop got=%h required=no_pop", p_out_cmd);
      end else begin
        logic [31:0] exp_w;
        exp_w = sb1.pop_front();
        if (p_out_cmd !== exp_w) begin
          errors++;
          $display("FAIL u1_pop_data got=%h required=%h", p_out_cmd, exp_w);
        end
      end
    end
    if (int'(count) > peak) peak = int'(count);
  end

  initial begin
    #1000000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [31:0] w, input logic sop);
    bit ok = 1'b0;
    in_word = w; in_sop = sop; in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL send_word_timeout in_ready=%0b required=1", in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_sop = 1'b0;
  endtask

  task automatic send_cmd(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                          input bit pop_last);
    sb.push_back({c, b, a});
    send_word(a, 1'b1);
    send_word(b, 1'b0);
    if (pop_last) out_ready = 1'b1;
    send_word(c, 1'b0);
    if (pop_last) out_ready = 1'b0;
  endtask

  task automatic wait_drain();
    bit ok = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && empty) begin ok = 1'b1; break; end
    end
    out_ready = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL drain_timeout left=%0d required=0", sb.size());
    end
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1; p_rst = 1'b1;
    in_word = '0; in_sop = 0; in_valid = 0; out_ready = 0; flush = 0; err_clr = 0;
    p_in_word = '0; p_in_sop = 0; p_in_valid = 0; p_out_ready = 0; p_flush = 0; p_err_clr = 0;
    repeat (3) step();
    rst = 1'b0; p_rst = 1'b0;
    checks += 7;
    if (count !== 5'd0)      begin errors++; $display("FAIL rst_count got=%0d required=0", count); end
    if (empty !== 1'b1)      begin errors++; $display("FAIL rst_empty got=%b required=1", empty); end
    if (full !== 1'b0)       begin errors++; $display("FAIL rst_full got=%b required=0", full); end
    if (almost_full !== 1'b0) begin errors++; $display("FAIL rst_af got=%b required=0", almost_full); end
    if (out_valid !== 1'b0)  begin errors++; $display("FAIL rst_out_valid got=%b required=0", out_valid); end
    if (err_frame !== 1'b0)  begin errors++; $display("FAIL rst_err got=%b required=0", err_frame); end
    if (in_ready !== 1'b1)   begin errors++; $display("FAIL rst_in_ready got=%b required=1", in_ready); end
  endtask

  task automatic test_defaults();
    peak = 0;
    out_ready = 1'b1;
    sb.push_back({32'd3, 32'd2, 32'd1});
    send_word(32'd1, 1'b1);
    send_word(32'd2, 1'b0);
    send_word(32'd3, 1'b0);
    checks += 2;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL first_latency out_valid=%b required=1", out_valid); end
    if (out_cmd !== 96'h00000003_00000002_00000001) begin
      errors++; $display("FAIL first_cmd got=%h required=000000030000000200000001", out_cmd);
    end
    send_cmd(32'd4, 32'd5, 32'd6, 1'b0);
    out_ready = 1'b1;
    send_cmd(32'd7, 32'd8, 32'd9, 1'b0);
    wait_drain();
    checks++;
    if (peak != 1) begin errors++; $display("FAIL count_peak got=%0d required=1", peak); end
  endtask

  task automatic test_fill();
    out_ready = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      send_cmd(32'h100 * k + 1, 32'h100 * k + 2, 32'h100 * k + 3, 1'b0);
      if (k == 13) begin checks++; if (almost_full !== 1'b0) begin errors++; $display("FAIL af_at_13 got=%b required=0", almost_full); end end
      if (k == 14) begin checks++; if (almost_full !== 1'b1) begin errors++; $display("FAIL af_at_14 got=%b required=1", almost_full); end end
      if (k == 15) begin checks++; if (full !== 1'b0) begin errors++; $display("FAIL full_at_15 got=%b required=0", full); end end
    end
    checks += 3;
    if (full !== 1'b1)     begin errors++; $display("FAIL full_at_16 got=%b required=1", full); end
    if (in_ready !== 1'b0) begin errors++; $display("FAIL in_ready_full got=%b required=0", in_ready); end
    if (count !== 5'd16)   begin errors++; $display("FAIL count_16 got=%0d required=16", count); end
    in_word = 32'hDEAD_BEEF; in_sop = 1'b1; in_valid = 1'b1;
    repeat (3) step();
    in_valid = 1'b0; in_sop = 1'b0;
    checks++;
    if (count !== 5'd16) begin errors++; $display("FAIL word17_rejected count=%0d required=16", count); end
  endtask

  task automatic test_simultaneous();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checks += 2;
    if (count !== 5'd15)   begin errors++; $display("FAIL pop_from_full count=%0d required=15", count); end
    if (in_ready !== 1'b1) begin errors++; $display("FAIL in_ready_after_pop got=%b required=1", in_ready); end
    wait_drain();
    checks++;
    if (count !== 5'd0) begin errors++; $display("FAIL drained_count got=%0d required=0", count); end
    for (int k = 0; k < 8; k++)
      send_cmd(32'hA000 + k, 32'hB000 + k, 32'hC000 + k, 1'b0);
    send_cmd(32'hA0FF, 32'hB0FF, 32'hC0FF, 1'b1);
    checks++;
    if (count !== 5'd8) begin errors++; $display("FAIL push_pop_count got=%0d required=8", count); end
    wait_drain();
  endtask

  task automatic test_framing();
    out_ready = 1'b1;
    send_word(32'hAAAA_0001, 1'b1);
    send_word(32'hBBBB_0002, 1'b0);
    send_word(32'hCCCC_0003, 1'b1);
    checks++;
    if (err_frame !== 1'b1) begin errors++; $display("FAIL err_sop_restart got=%b required=1", err_frame); end
    sb.push_back({32'hEEEE_0005, 32'hDDDD_0004, 32'hCCCC_0003});
    send_word(32'hDDDD_0004, 1'b0);
    send_word(32'hEEEE_0005, 1'b0);
    wait_drain();
    err_clr = 1'b1; step(); err_clr = 1'b0;
    checks++;
    if (err_frame !== 1'b0) begin errors++; $display("FAIL err_clear got=%b required=0", err_frame); end
    out_ready = 1'b1;
    send_word(32'h5555_0006, 1'b0);
    checks++;
    if (err_frame !== 1'b1) begin errors++; $display("FAIL err_orphan_word got=%b required=1", err_frame); end
    err_clr = 1'b1; step(); err_clr = 1'b0;
    err_clr = 1'b1;
    send_word(32'h6666_0007, 1'b0);
    err_clr = 1'b0;
    checks++;
    if (err_frame !== 1'b1) begin errors++; $display("FAIL err_set_wins got=%b required=1", err_frame); end
    err_clr = 1'b1; step(); err_clr = 1'b0;
    out_ready = 1'b1;
    send_cmd(32'hF001, 32'hF002, 32'hF003, 1'b0);
    wait_drain();
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++)
      send_cmd(32'h7000 + k, 32'h7100 + k, 32'h7200 + k, 1'b0);
    send_word(32'h0BAD_0001, 1'b0);
    send_word(32'h0BAD_0002, 1'b1);
    flush = 1'b1; in_valid = 1'b1; in_sop = 1'b0; in_word = 32'h0BAD_0003; out_ready = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    sb.delete();
    checks += 4;
    if (count !== 5'd0)     begin errors++; $display("FAIL flush_count got=%0d required=0", count); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid got=%b required=0", out_valid); end
    if (empty !== 1'b1)     begin errors++; $display("FAIL flush_empty got=%b required=1", empty); end
    if (err_frame !== 1'b1) begin errors++; $display("FAIL flush_err_kept got=%b required=1", err_frame); end
    err_clr = 1'b1; step(); err_clr = 1'b0;
    send_cmd(32'h9001, 32'h9002, 32'h9003, 1'b0);
    wait_drain();
    checks++;
    if (err_frame !== 1'b0) begin errors++; $display("FAIL flush_widx_reset err=%b required=0", err_frame); end
  endtask

  task automatic test_param();
    bit ok = 1'b0;
    p_out_ready = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      p_in_word = 32'hA0 + k; p_in_sop = 1'($urandom_range(0, 1)); p_in_valid = 1'b1;
      sb1.push_back(32'hA0 + k);
      step();
      p_in_valid = 1'b0;
      if (k == 2) begin checks++; if (p_almost_full !== 1'b0) begin errors++; $display("FAIL p_af_at_2 got=%b required=0", p_almost_full); end end
      if (k == 3) begin
        checks += 2;
        if (p_almost_full !== 1'b1) begin errors++; $display("FAIL p_af_at_3 got=%b required=1", p_almost_full); end
        if (p_full !== 1'b0)        begin errors++; $display("FAIL p_full_at_3 got=%b required=0", p_full); end
      end
    end
    checks += 3;
    if (p_full !== 1'b1)     begin errors++; $display("FAIL p_full_at_4 got=%b required=1", p_full); end
    if (p_in_ready !== 1'b0) begin errors++; $display("FAIL p_in_ready_full got=%b required=0", p_in_ready); end
    if (p_count !== 3'd4)    begin errors++; $display("FAIL p_count_4 got=%0d required=4", p_count); end
    p_out_ready = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (sb1.size() == 0 && p_empty) begin ok = 1'b1; break; end
    end
    p_out_ready = 1'b0;
    checks++;
    if (!ok) begin errors++; $display("FAIL p_drain_timeout left=%0d required=0", sb1.size()); end
    step();
    p_in_valid = 1'b1; p_in_word = 32'hC1; step();
    p_in_word = 32'hC2; step();
    p_rst = 1'b1; p_out_ready = 1'b1; p_in_word = 32'hC3;
    step();
    p_rst = 1'b0; p_in_valid = 1'b0; p_out_ready = 1'b0;
    checks += 3;
    if (p_count !== 3'd0)     begin errors++; $display("FAIL p_rst_count got=%0d required=0", p_count); end
    if (p_empty !== 1'b1)     begin errors++; $display("FAIL p_rst_empty got=%b required=1", p_empty); end
    if (p_out_valid !== 1'b0) begin errors++; $display("FAIL p_rst_out_valid got=%b required=0", p_out_valid); end
  endtask

  initial begin
    test_reset();
    test_defaults();
    test_fill();
    test_simultaneous();
    test_framing();
    test_flush();
    test_param();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
